out_byte_uart_tx: RTL and testbench
===================================

OUT_BYTE_UART_TX -- requirements
Module: out_byte_uart_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 868, clock cycles per UART bit (≥2).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, byte FIFO entries (power of two, ≥2).
REQ-003 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-004 SHALL have port resetn_i  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_byte  input  8  byte from the core's output-byte port.
REQ-006 SHALL have port in_byte_en  input  1  single-cycle strobe qualifying in_byte; no backpressure exists.
REQ-007 SHALL have port tx  output  1  UART serial line, 8N1, idle high.
REQ-008 SHALL have port busy  output  1  high while a frame is on the line or the FIFO is non-empty.
REQ-009 SHALL have port fifo_full  output  1  FIFO holds FIFO_DEPTH bytes.
REQ-010 SHALL have port overflow  output  1  one-cycle pulse, the cycle after a strobe is dropped.
REQ-011 SHALL have port drop_count  output  8  saturating count of dropped bytes.

Function
REQ-012 SHALL write in_byte into the FIFO on each edge where in_byte_en=1 and fifo_full=0.
REQ-013 SHALL drop the byte when in_byte_en=1 and fifo_full=0 is false (full from registered count, even if a pop occurs that same edge), pulse overflow, increment drop_count, saturating at 255.
REQ-014 SHALL allow simultaneous push and pop when not full; count unchanged.
REQ-015 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-016 IDLE: tx=1; if FIFO non-empty, pop head into shift register, baud counter=0, go START.
REQ-017 START: tx=0 for CLK_DIV cycles, then DATA with bit index 0.
REQ-018 DATA: tx=shift[0], LSB first, each bit CLK_DIV cycles; after bit 7 go STOP.
REQ-019 STOP: tx=1 for CLK_DIV cycles; then if FIFO non-empty pop and go START directly (no idle cycle), else go IDLE.
REQ-020 Frame length SHALL be exactly 10*CLK_DIV cycles; back-to-back frames contiguous.
REQ-021 Latency: strobe sampled at edge N into empty FIFO with FSM IDLE -> tx falls after edge N+1.
REQ-022 Baud counter SHALL count 0..CLK_DIV-1 and wrap; width clog2(CLK_DIV).
REQ-023 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
REQ-024 tx SHALL be driven from a flop (glitch-free).

Reset
REQ-025 While resetn_i=0: tx=1, busy=0, fifo_full=0, overflow=0, drop_count=0, FSM=IDLE, FIFO empty, counters 0; asserted asynchronously, including mid-frame.
REQ-026 Frame in progress at reset SHALL be abandoned; no partial frame resumes after release.
REQ-027 First strobe accepted on the first edge with resetn_i=1.

Structure
REQ-028 Package uart_tx_pkg SHALL hold FSM state encodings, DATA_BITS=8, and the default CLK_DIV.
REQ-029 FIFO SHALL be sub-module byte_fifo (sync, 8-bit, parameterised depth, push/pop/full/empty/count).
REQ-030 FSM, baud counter, shift register, and drop logic SHALL reside in out_byte_uart_tx.

Verification (CLK_DIV=4, FIFO_DEPTH=16)
REQ-031 Single 0x55 strobe at edge N -> tx low from edge N+1, then bits 1,0,1,0,1,0,1,0 LSB first, then stop 1, 4 cycles each; busy low after 40 cycles.
REQ-032 Strobes 0xA5 then 0x3C, 1 cycle apart -> two contiguous 40-cycle frames, no idle gap; busy stays high 80 cycles.
REQ-033 20 consecutive strobes from empty -> 17 accepted (1 in shifter + 16 FIFO), fifo_full high, 3 overflow pulses, drop_count=3.
REQ-034 resetn_i low mid-DATA of a frame with 5 bytes queued -> tx=1 immediately, busy=0, drop_count=0; after release no frame without new strobe.
REQ-035 300 strobes while full -> drop_count saturates at 255, no wrap.
REQ-036 Strobe on the edge STOP ends with FIFO empty -> byte accepted and next START begins after following edge, per REQ-021.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the output-byte UART transmitter: FSM encoding,
// frame geometry and the default bit period.
package uart_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam int DATA_BITS       = 8;
    localparam int DEFAULT_CLK_DIV = 868;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous 8-bit FIFO with power-of-two depth; pointers wrap naturally.
// Push is ignored when full, pop is ignored when empty.
module byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     resetn_i,
    input  logic                     push,
    input  logic [7:0]               wdata,
    input  logic                     pop,
    output logic [7:0]               rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage is left unreset; only the bookkeeping defines validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge resetn_i) begin
        if (!resetn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/out_byte_uart_tx.sv
// Buffers bytes strobed from the core's output port and serialises them as
// 8N1 UART frames; bytes arriving while the FIFO is full are dropped and counted.
module out_byte_uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLK_DIV    = DEFAULT_CLK_DIV,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        resetn_i,
    input  logic [7:0]  in_byte,
    input  logic        in_byte_en,
    output logic        tx,
    output logic        busy,
    output logic        fifo_full,
    output logic        overflow,
    output logic [7:0]  drop_count,
    output uart_state_e state
);

    localparam int            CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] BAUD_MAX = CW'(CLK_DIV - 1);
    localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);
    localparam int            CNTW     = $clog2(FIFO_DEPTH) + 1;

    logic            push;
    logic            pop;
    logic            drop;
    logic            fifo_empty;
    logic [7:0]      fifo_rdata;
    logic [CNTW-1:0] fifo_count;
    logic [CW-1:0]   baud_cnt;
    logic            baud_done;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;

    // Full is the registered flag, so a pop on the same edge never frees a slot.
    assign push      = in_byte_en && !fifo_full;
    assign drop      = in_byte_en && fifo_full;
    assign baud_done = (baud_cnt == BAUD_MAX);
    assign pop       = !fifo_empty && ((state == ST_IDLE) || (state == ST_STOP && baud_done));
    assign busy      = (state != ST_IDLE) || (fifo_count != '0);

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .resetn_i (resetn_i),
        .push     (push),
        .wdata    (in_byte),
        .pop      (pop),
        .rdata    (fifo_rdata),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // Frame sequencer; tx is registered here so the line never glitches.
    always_ff @(posedge clk or negedge resetn_i) begin
        if (!resetn_i) begin
            state    <= ST_IDLE;
            tx       <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
        end else begin
            baud_cnt <= baud_done ? '0 : baud_cnt + 1'b1;
            case (state)
                ST_IDLE: begin
                    baud_cnt <= '0;
                    tx       <= 1'b1;
                    if (pop) begin
                        shift <= fifo_rdata;
                        tx    <= 1'b0;
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_done) begin
                        tx      <= shift[0];
                        shift   <= shift >> 1;
                        bit_idx <= '0;
                        state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (baud_done) begin
                        if (bit_idx == LAST_BIT) begin
                            tx    <= 1'b1;
                            state <= ST_STOP;
                        end else begin
                            tx      <= shift[0];
                            shift   <= shift >> 1;
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    // Chain straight into the next start bit when data is waiting.
                    if (baud_done) begin
                        if (pop) begin
                            shift <= fifo_rdata;
                            tx    <= 1'b0;
                            state <= ST_START;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn_i) begin
        if (!resetn_i) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            overflow <= drop;
            if (drop && drop_count != 8'hFF) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_out_byte_uart_tx.sv
// Directed + randomized bench for out_byte_uart_tx with CLK_DIV=4, FIFO_DEPTH=16,
// checked against a frame-level model of the serial line and byte queue.
module tb_out_byte_uart_tx;
    import uart_tx_pkg::*;

    localparam int CLK_DIV    = 4;
    localparam int FIFO_DEPTH = 16;

    // clock / reset
    logic        clk = 1'b0;
    logic        resetn_i = 1'b0;
    logic [7:0]  in_byte = 8'h00;
    logic        in_byte_en = 1'b0;
    logic        tx;
    logic        busy;
    logic        fifo_full;
    logic        overflow;
    logic [7:0]  drop_count;
    uart_state_e state_dbg;

    always #5 clk = ~clk;

    out_byte_uart_tx #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .resetn_i   (resetn_i),
        .in_byte    (in_byte),
        .in_byte_en (in_byte_en),
        .tx         (tx),
        .busy       (busy),
        .fifo_full  (fifo_full),
        .overflow   (overflow),
        .drop_count (drop_count),
        .state      (state_dbg)
    );

    // reference model: queued bytes plus the remaining per-cycle line levels
    logic [7:0] exp_q[$];
    logic       line_q[$];
    int         m_drops = 0;
    int         checks = 0;
    int         failures = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        line_q.delete();
        m_drops = 0;
    endtask

    // One clock: drive inputs, update model at the edge, compare 1ns later.
    task automatic step(input logic en, input logic [7:0] b);
        logic [7:0] frame_byte;
        logic       full_pre;
        logic       dropped;
        logic       in_frame;
        logic       exp_tx;
        in_byte_en = en;
        in_byte    = b;
        @(posedge clk);
        full_pre = (exp_q.size() == FIFO_DEPTH);
        if (line_q.size() == 0 && exp_q.size() != 0) begin
            frame_byte = exp_q.pop_front();
            for (int c = 0; c < CLK_DIV; c++) line_q.push_back(1'b0);
            for (int i = 0; i < 8; i++)
                for (int c = 0; c < CLK_DIV; c++) line_q.push_back(frame_byte[i]);
            for (int c = 0; c < CLK_DIV; c++) line_q.push_back(1'b1);
        end
        dropped = en && full_pre;
        if (en && !full_pre) exp_q.push_back(b);
        if (dropped && m_drops < 255) m_drops++;
        in_frame = (line_q.size() != 0);
        exp_tx   = in_frame ? line_q.pop_front() : 1'b1;
        #1;
        chk("tx", 8'(tx), 8'(exp_tx));
        chk("busy", 8'(busy), 8'(in_frame || exp_q.size() != 0));
        chk("fifo_full", 8'(fifo_full), 8'(exp_q.size() == FIFO_DEPTH));
        chk("overflow", 8'(overflow), 8'(dropped));
        chk("drop_count", drop_count, 8'(m_drops));
        in_byte_en = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    task automatic drain();
        for (int i = 0; i < 2000 && (line_q.size() != 0 || exp_q.size() != 0); i++)
            step(1'b0, 8'h00);
        idle(2);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tx"}, 8'(tx), 8'h01);
        chk({tag, "_busy"}, 8'(busy), 8'h00);
        chk({tag, "_full"}, 8'(fifo_full), 8'h00);
        chk({tag, "_ovf"}, 8'(overflow), 8'h00);
        chk({tag, "_drops"}, drop_count, 8'h00);
        chk({tag, "_state"}, 8'(state_dbg), 8'(ST_IDLE));
    endtask

    initial begin
        // reset state
        #12;
        chk_reset_outputs("rst");
        @(posedge clk);
        #1 resetn_i = 1'b1;

        // single 0x55 on the first edge out of reset
        step(1'b1, 8'h55);
        idle(45);

        // two strobes on consecutive edges -> contiguous frames
        step(1'b1, 8'hA5);
        step(1'b1, 8'h3C);
        idle(85);

        // 20 consecutive strobes from empty -> 3 dropped
        for (int i = 0; i < 20; i++) step(1'b1, 8'($urandom_range(0, 255)));
        chk("burst_drops", drop_count, 8'd3);
        chk("burst_full", 8'(fifo_full), 8'h01);
        drain();

        // strobe landing on the edge that ends STOP with an empty FIFO
        step(1'b1, 8'hC3);
        idle(40);
        step(1'b1, 8'h81);
        idle(45);

        // random traffic
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 3) == 0, 8'($urandom_range(0, 255)));
        drain();

        // asynchronous reset mid-DATA with 5 bytes queued
        for (int i = 0; i < 6; i++) step(1'b1, 8'($urandom_range(0, 255)));
        idle(20);
        #3 resetn_i = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 resetn_i = 1'b1;
        idle(50);

        // saturation of drop_count
        for (int i = 0; i < 320; i++) step(1'b1, 8'($urandom_range(0, 255)));
        chk("drop_sat", drop_count, 8'hFF);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
